// File: rtl/proc_pkg.sv
// Shared definitions for the processor control path: opcodes, ALU operation codes
// and the timestep encoding of the control FSM.
package proc_pkg;

   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_MVI  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_MVNZ = 4'b1000;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0101;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_AND);
   endfunction

   function automatic logic [3:0] alu_code(input logic [3:0] op);
      logic [3:0] code;
      case (op)
         OP_SUB:  code = ALU_SUB;
         OP_SLT:  code = ALU_SLT;
         OP_SLL:  code = ALU_SLL;
         OP_SRL:  code = ALU_SRL;
         OP_AND:  code = ALU_AND;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/dec3to8.sv
// Index to one-hot decoder with enable; drives the register-file write and
// bus-drive selects.
module dec3to8 #(
   parameter int IDX_W = 3
) (
   input  logic [IDX_W-1:0]    idx,
   input  logic                en,
   output logic [2**IDX_W-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control FSM for the 16-bit processor datapath: fetches into IR in T0,
// then sequences register, bus, A/G and ALU controls over T1..T3.
module proc_control
   import proc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                Run,
   input  logic [DATA_W-1:0]   DIN,
   input  logic                G_nz,
   output logic                IRin,
   output logic [2**REG_W-1:0] Rin,
   output logic [2**REG_W-1:0] Rout,
   output logic                DINout,
   output logic                Gout,
   output logic                Ain,
   output logic                Gin,
   output logic [3:0]          alu_op,
   output logic                Done,
   output logic [DATA_W-1:0]   IR
);

   state_t            state, state_next;
   logic [DATA_W-1:0] ir_q;
   logic [3:0]        opcode;
   logic [REG_W-1:0]  rx, ry, rout_idx;
   logic              irin_raw, rin_en, rout_en;

   assign opcode = ir_q[15:12];
   assign rx     = ir_q[11:9];
   assign ry     = ir_q[8:6];
   assign IR     = ir_q;

   // NOTE: state-holding processes use non-blocking assignments only, so every
   // flop samples the values from before the edge regardless of statement order.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= T0;
         ir_q  <= '0;
      end else begin
         state <= state_next;
         if (state == T0 && Run) ir_q <= DIN;
      end
   end

   // NOTE: every signal written here gets a default first; a path that skips an
   // assignment would otherwise infer a latch.
   always_comb begin
      state_next = state;
      irin_raw   = 1'b0;
      rin_en     = 1'b0;
      rout_en    = 1'b0;
      rout_idx   = ry;
      DINout     = 1'b0;
      Gout       = 1'b0;
      Ain        = 1'b0;
      Gin        = 1'b0;
      alu_op     = ALU_ADD;
      Done       = 1'b0;

      case (state)
         T0: begin
            irin_raw = Run;
            if (Run) state_next = T1;
         end
         T1: begin
            if (is_alu_op(opcode)) begin
               rout_en    = 1'b1;
               rout_idx   = rx;
               Ain        = 1'b1;
               state_next = T2;
            end else begin
               case (opcode)
                  OP_MV: begin
                     rout_en = 1'b1;
                     rin_en  = 1'b1;
                  end
                  OP_MVI: begin
                     DINout = 1'b1;
                     rin_en = 1'b1;
                  end
                  OP_MVNZ: begin
                     rout_en = G_nz;
                     rin_en  = G_nz;
                  end
                  default: ;
               endcase
               Done       = 1'b1;
               state_next = T0;
            end
         end
         T2: begin
            rout_en    = 1'b1;
            Gin        = 1'b1;
            alu_op     = alu_code(opcode);
            state_next = T3;
         end
         T3: begin
            Gout       = 1'b1;
            rin_en     = 1'b1;
            Done       = 1'b1;
            state_next = T0;
         end
         default: state_next = T0;
      endcase
   end

   // Reset holds the FSM in T0, where IRin is the only output still tied to Run.
   assign IRin = irin_raw & Resetn;

   dec3to8 #(.IDX_W(REG_W)) u_dec_rin (
      .idx    (rx),
      .en     (rin_en),
      .onehot (Rin)
   );

   dec3to8 #(.IDX_W(REG_W)) u_dec_rout (
      .idx    (rout_idx),
      .en     (rout_en),
      .onehot (Rout)
   );

endmodule
